// File: rtl/ps2_keypad_rx.sv
// ----------------------------------------------------------------------------
// ps2_keypad_rx
//
// PS/2 keyboard receiver and key decoder. The raw PS/2 lines are
// synchronised, the clock line is debounced, and 11-bit frames are assembled
// and checked. The decoder tracks the break (F0) and extended (E0) prefixes
// and turns each final scancode byte into a one-cycle key event with digit
// and direction lookups.
//
// Parameters
//   FILTER_LEN     : consecutive equal ps2_clk samples needed to change the
//                    filtered clock (2..255)
//   TIMEOUT_CYCLES : idle clk cycles allowed inside a frame before abort
//   ENABLE_ARROWS  : 1 = E0-prefixed arrow keys map to directions
//
// Ports
//   clk, rst_n     : system clock, asynchronous active-low reset
//   ps2_clk        : raw PS/2 clock (asynchronous)
//   ps2_data       : raw PS/2 data (asynchronous)
//   key_valid      : one-cycle pulse, key event present on outputs below
//   key_release    : 1 = break, 0 = make (held until next event)
//   numbers        : digit 0..9, 4'hF = not a digit (held)
//   directions     : 000 up, 001 left, 010 down, 011 right, 111 none (held)
//   scancode       : final non-prefix byte of the event (held)
//   extended       : event was E0-prefixed (held)
//   frame_error    : one-cycle pulse on bad start/stop/parity or timeout
// ----------------------------------------------------------------------------
module ps2_keypad_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter bit ENABLE_ARROWS  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_valid,
   output logic       key_release,
   output logic [3:0] numbers,
   output logic [2:0] directions,
   output logic [7:0] scancode,
   output logic       extended,
   output logic       frame_error
);

   localparam int               TO_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]       FILT_LAST = 8'(FILTER_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   // -------------------------------------------------------------------------
   // Two-stage synchronisers; index 0 = ps2_clk, index 1 = ps2_data.
   // Both lines idle high, so the flops reset high to avoid a false edge.
   // -------------------------------------------------------------------------
   logic [1:0] pin_raw;
   logic [1:0] pin_sync;

   assign pin_raw = {ps2_data, ps2_clk};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         logic [1:0] sync_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_reg <= 2'b11;
            end else begin
               sync_reg <= {sync_reg[0], pin_raw[gi]};
            end
         end
         assign pin_sync[gi] = sync_reg[1];
      end
   endgenerate

   logic clk_s;
   logic data_s;

   assign clk_s  = pin_sync[0];
   assign data_s = pin_sync[1];

   // -------------------------------------------------------------------------
   // Clock filter: the k-th consecutive sample differing from the filtered
   // level sees filt_cnt_reg = k-1, so the level flips on the FILTER_LEN-th.
   // fall_reg is registered together with the flip to a low level.
   // -------------------------------------------------------------------------
   logic       filt_clk_reg;
   logic [7:0] filt_cnt_reg;
   logic       fall_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_clk_reg <= 1'b1;
         filt_cnt_reg <= 8'd0;
         fall_reg     <= 1'b0;
      end else begin
         fall_reg <= 1'b0;
         if (clk_s != filt_clk_reg) begin
            if (filt_cnt_reg == FILT_LAST) begin
               filt_clk_reg <= clk_s;
               filt_cnt_reg <= 8'd0;
               fall_reg     <= ~clk_s;
            end else begin
               filt_cnt_reg <= filt_cnt_reg + 8'd1;
            end
         end else begin
            filt_cnt_reg <= 8'd0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Receive FSM and decoder state
   // -------------------------------------------------------------------------
   state_t          state_reg;
   logic [10:0]     shift_reg;
   logic [3:0]      bit_cnt_reg;
   logic [TO_W-1:0] to_cnt_reg;
   logic            frame_ok_reg;
   logic            brk_pend_reg;
   logic            ext_pend_reg;

   // Frame as it will look once the bit on the current fall is shifted in.
   // Bits arrive LSB-first and enter at the top, so after 11 shifts bit 0
   // holds the start bit and bit 10 the stop bit.
   logic [10:0] frame_next;
   logic        frame_ok_next;
   logic [7:0]  rx_byte;

   assign frame_next    = {data_s, shift_reg[10:1]};
   assign frame_ok_next = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);
   assign rx_byte       = shift_reg[8:1];

   // -------------------------------------------------------------------------
   // Key lookup for the byte held in the shift register
   // -------------------------------------------------------------------------
   logic [3:0] dig_map;
   logic [2:0] dir_map;

   always_comb begin
      dig_map = 4'hF;
      dir_map = 3'b111;
      if (!ext_pend_reg) begin
         case (rx_byte)
            8'h16:   dig_map = 4'd1;
            8'h1E:   dig_map = 4'd2;
            8'h26:   dig_map = 4'd3;
            8'h25:   dig_map = 4'd4;
            8'h2E:   dig_map = 4'd5;
            8'h36:   dig_map = 4'd6;
            8'h3D:   dig_map = 4'd7;
            8'h3E:   dig_map = 4'd8;
            8'h46:   dig_map = 4'd9;
            8'h45:   dig_map = 4'd0;
            default: dig_map = 4'hF;
         endcase
         case (rx_byte)
            8'h1D:   dir_map = 3'b000;
            8'h1C:   dir_map = 3'b001;
            8'h1B:   dir_map = 3'b010;
            8'h23:   dir_map = 3'b011;
            default: dir_map = 3'b111;
         endcase
      end else if (ENABLE_ARROWS) begin
         case (rx_byte)
            8'h75:   dir_map = 3'b000;
            8'h6B:   dir_map = 3'b001;
            8'h72:   dir_map = 3'b010;
            8'h74:   dir_map = 3'b011;
            default: dir_map = 3'b111;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Frame assembly, checking and event generation.
   // The frame check is evaluated on the stop-bit fall so frame_error leads
   // by one cycle; the CHECK cycle then registers the decoded event.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         shift_reg    <= 11'd0;
         bit_cnt_reg  <= 4'd0;
         to_cnt_reg   <= '0;
         frame_ok_reg <= 1'b0;
         brk_pend_reg <= 1'b0;
         ext_pend_reg <= 1'b0;
         key_valid    <= 1'b0;
         key_release  <= 1'b0;
         numbers      <= 4'hF;
         directions   <= 3'b111;
         scancode     <= 8'h00;
         extended     <= 1'b0;
         frame_error  <= 1'b0;
      end else begin
         key_valid   <= 1'b0;
         frame_error <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (fall_reg) begin
                  shift_reg   <= frame_next;
                  bit_cnt_reg <= 4'd1;
                  to_cnt_reg  <= '0;
                  state_reg   <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               if (fall_reg) begin
                  shift_reg  <= frame_next;
                  to_cnt_reg <= '0;
                  if (bit_cnt_reg == 4'd10) begin
                     frame_ok_reg <= frame_ok_next;
                     if (!frame_ok_next) begin
                        frame_error  <= 1'b1;
                        brk_pend_reg <= 1'b0;
                        ext_pend_reg <= 1'b0;
                     end
                     state_reg <= ST_CHECK;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                  end
               end else if (to_cnt_reg == TO_LAST) begin
                  // Keyboard stalled mid-frame: drop it and any prefix.
                  frame_error  <= 1'b1;
                  brk_pend_reg <= 1'b0;
                  ext_pend_reg <= 1'b0;
                  state_reg    <= ST_IDLE;
               end else begin
                  to_cnt_reg <= to_cnt_reg + 1'b1;
               end
            end

            ST_CHECK: begin
               state_reg <= ST_IDLE;
               if (frame_ok_reg) begin
                  if (rx_byte == 8'hE0) begin
                     ext_pend_reg <= 1'b1;
                  end else if (rx_byte == 8'hF0) begin
                     brk_pend_reg <= 1'b1;
                  end else begin
                     key_valid    <= 1'b1;
                     key_release  <= brk_pend_reg;
                     extended     <= ext_pend_reg;
                     scancode     <= rx_byte;
                     numbers      <= dig_map;
                     directions   <= dir_map;
                     brk_pend_reg <= 1'b0;
                     ext_pend_reg <= 1'b0;
                  end
               end
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule
